// File: rtl/led_blink_multi.sv
// Multi-channel LED pattern generator: shared tick prescaler plus per-channel
// programmable period, on-time and mode (off / on / blink / counted burst).
module led_blink_multi #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 125_000_000 / 1000,
  parameter int PW       = 16,
  parameter int CW       = 8,
  parameter int TW       = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync_i,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [PW-1:0]   cfg_period,
  input  logic [PW-1:0]   cfg_on,
  input  logic [CW-1:0]   cfg_count,
  output logic [N_CH-1:0] led_o,
  output logic [N_CH-1:0] done_o,
  output logic            tick_o
);

  // state    | meaning
  // M_OFF    | led dark, phase held at 0
  // M_ON     | led lit, phase held at 0
  // M_BLINK  | led = ph < D, free-running period
  // M_BURST  | as blink, drops to M_OFF with done set after rc periods
  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_t;

  logic [TW-1:0] pc;
  logic          tick;
  logic          wr_hit;

  mode_t         mode_r  [N_CH];
  logic [PW-1:0] per_r   [N_CH];
  logic [PW-1:0] on_r    [N_CH];
  logic [PW-1:0] ph_r    [N_CH];
  logic [CW-1:0] rc_r    [N_CH];

  mode_t         mode_n  [N_CH];
  logic [PW-1:0] per_n   [N_CH];
  logic [PW-1:0] on_n    [N_CH];
  logic [PW-1:0] ph_n    [N_CH];
  logic [CW-1:0] rc_n    [N_CH];
  logic [PW-1:0] pe_m1   [N_CH];
  logic [N_CH-1:0] done_n;
  logic [N_CH-1:0] led_n;

  assign tick   = (pc == TW'(TICK_DIV - 1));
  assign tick_o = tick;
  assign wr_hit = cfg_we && ({1'b0, cfg_ch} < 5'(N_CH));

  function automatic logic lit_f(mode_t m, logic [PW-1:0] ph, logic [PW-1:0] d);
    case (m)
      M_ON:             return 1'b1;
      M_BLINK, M_BURST: return (ph < d);
      default:          return 1'b0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_n[i] = mode_r[i];
      per_n[i]  = per_r[i];
      on_n[i]   = on_r[i];
      ph_n[i]   = ph_r[i];
      rc_n[i]   = rc_r[i];
      done_n[i] = done_o[i];
      // P = 0 behaves as a one-tick period
      pe_m1[i]  = (per_r[i] == '0) ? '0 : per_r[i] - PW'(1);

      if (wr_hit && (cfg_ch == 4'(i))) begin
        mode_n[i] = mode_t'(cfg_mode);
        per_n[i]  = cfg_period;
        on_n[i]   = cfg_on;
        rc_n[i]   = cfg_count;
        ph_n[i]   = '0;
        done_n[i] = 1'b0;
        if ((mode_t'(cfg_mode) == M_BURST) && (cfg_count == '0)) begin
          mode_n[i] = M_OFF;
          done_n[i] = 1'b1;
        end
      end else if (sync_i || (mode_r[i] == M_OFF) || (mode_r[i] == M_ON)) begin
        ph_n[i] = '0;
      end else if (tick) begin
        if (ph_r[i] == pe_m1[i]) begin
          ph_n[i] = '0;
          if (mode_r[i] == M_BURST) begin
            if (rc_r[i] <= CW'(1)) begin
              mode_n[i] = M_OFF;
              rc_n[i]   = '0;
              done_n[i] = 1'b1;
            end else begin
              rc_n[i] = rc_r[i] - CW'(1);
            end
          end
        end else begin
          ph_n[i] = ph_r[i] + PW'(1);
        end
      end

      led_n[i] = lit_f(mode_n[i], ph_n[i], on_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= '0;
      led_o  <= '0;
      done_o <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= M_OFF;
        per_r[i]  <= '0;
        on_r[i]   <= '0;
        ph_r[i]   <= '0;
        rc_r[i]   <= '0;
      end
    end else begin
      if (sync_i || tick) pc <= '0;
      else                pc <= pc + TW'(1);
      led_o  <= led_n;
      done_o <= done_n;
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= mode_n[i];
        per_r[i]  <= per_n[i];
        on_r[i]   <= on_n[i];
        ph_r[i]   <= ph_n[i];
        rc_r[i]   <= rc_n[i];
      end
    end
  end

endmodule

// File: doc/led_blink_multi.md
# led_blink_multi

Multi-channel, parametrised LED pattern generator: the next generation of the single-channel 1 Hz blinker. A shared free-running prescaler produces a tick strobe. Each of N_CH channels runs its own run-time-programmable period, on-time and mode (off, on, continuous blink, counted burst). It sits between the board clock and the user LEDs and is configured through a simple single-cycle write port by control logic or a test harness.

## Interface
- N_CH, 4: number of LED channels (1..16)
- TICK_DIV, 125_000_000/1000: clock cycles per tick (≥2); default gives 1 ms ticks at 125 MHz
- PW, 16: width of period and on-time fields, in ticks
- CW, 8: width of burst count field
- TW, 27: width of prescaler counter, ≥ ceil(log2(TICK_DIV))

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sync_i  in  1  one-cycle pulse; realigns prescaler and all channel phases
- cfg_we  in  1  config write strobe, single cycle, no back-pressure
- cfg_ch  in  4  target channel index
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
- cfg_period  in  PW  period P in ticks
- cfg_on  in  PW  on-time D in ticks
- cfg_count  in  CW  burst length in periods (BURST only)
- led_o  out  N_CH  registered LED drive, 1 = lit
- done_o  out  N_CH  sticky burst-complete flag per channel
- tick_o  out  1  prescaler tick strobe, for debug and test

## Operation
- Prescaler: counter pc counts 0..TICK_DIV-1 and wraps. tick_o = 1 for the single cycle where pc == TICK_DIV-1. It is free-running and is not disturbed by cfg writes.
- Per channel, registers: mode, P, D, remaining burst count rc, phase ph (PW bits), done.
- Effective period Pe = max(P,1). A channel is lit when ph < D, so D=0 gives always dark and D ≥ Pe gives always lit.
- On each tick, ph advances: ph = (ph == Pe-1) ? 0 : ph+1. The wrap is the period boundary.
- OFF: led 0, ph held at 0.
- ON: led 1, ph held at 0.
- BLINK: led = (ph < D), repeating indefinitely.
- BURST:
  - led = (ph < D).
  - At each period boundary rc decrements.
  - At the boundary where rc == 1, mode becomes OFF and done is set.
  - cfg_count = 0: the write itself loads mode OFF and sets done; led stays 0.
- Write (cfg_we=1, cfg_ch < N_CH):
  - Loads mode, P, D; sets rc = cfg_count.
  - Sets ph = 0 and clears done (except in the count=0 case above).
  - Writes with cfg_ch ≥ N_CH are ignored entirely.
- sync_i: pc → 0 and every channel's ph → 0. Modes, rc and done are unchanged.
- Precedence, same cycle:
  - rst_n beats everything.
  - A write to a channel beats that channel's tick advance and burst decrement.
  - Write and sync together: both apply, and the written channel's ph = 0 either way.
  - Tick and sync together: sync wins, ph = 0, no advance.
- Arithmetic is unsigned. ph compare uses the PW-bit values. No overflow is possible, since ph < Pe ≤ 2^PW-1.

## Timing
- Reset, one clk edge with rst_n=0: pc=0, all modes OFF, ph=0, rc=0, led_o=0, done_o=0, tick_o=0. A reset mid-burst aborts the burst with no done.
- led_o is registered and reflects the state loaded at the same edge. A write at edge t shows the new led value after t, i.e. 1-cycle latency.
- After a write without sync, the first phase slot lasts 1..TICK_DIV cycles. After sync_i at edge t, the first tick lands at edge t+TICK_DIV and every phase slot is exactly TICK_DIV cycles.
- done_o rises on the edge of the final boundary tick, the same edge at which led_o drops. It stays high until the next write to that channel or reset.
- tick_o is high exactly 1 of every TICK_DIV cycles.

## Test plan
All cases use TICK_DIV=4, N_CH=4, PW=8, CW=8.
- Reset: hold rst_n=0 for 2 cycles mid-operation -> led_o=0000, done_o=0000, tick_o first high 4 cycles after release.
- BLINK: write ch0 mode=2 P=4 D=1, then sync_i -> led_o[0] high 4 cycles, low 12 cycles, repeating; other channels stay 0.
- Degenerate fields:
  - ch1 BLINK P=3 D=5 -> led_o[1] constantly 1.
  - ch1 BLINK P=0 D=0 -> constantly 0.
  - ch1 mode=1 -> 1 within 1 cycle.
- BURST: ch2 mode=3 P=2 D=1 count=3 after sync -> three 4-cycle high pulses 8 cycles apart. led_o[2]=0 and done_o[2]=1 from cycle 24. A rewrite of ch2 clears done_o[2].
- Edge cases:
  - BURST with count=0 -> done_o set next cycle, LED dark.
  - A write with cfg_ch=5 -> no state change.
  - A write to ch0 on a tick cycle -> ph restarts at 0 with no advance.
- Reset mid-burst: rst_n=0 during the second pulse of a count=5 burst -> led_o=0 and done_o=0, no further pulses.
